// File: rtl/ra_pkg.sv
// rtl/ra_pkg.sv - shared types and helpers for the rolling-average serial output
package ra_pkg;

   localparam int RA_BITS_PER_ELEM = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Serial bits per frame: start + data + optional parity + stop.
   function automatic int frame_bits(input int bits, input int parity_en);
      return 2 + bits + parity_en;
   endfunction

endpackage

// File: rtl/ra_baud_tick.sv
// rtl/ra_baud_tick.sv - bit-time down-counter with clear, one-cycle tick every CLKS_PER_BIT clocks
module ra_baud_tick
   import ra_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt_q;

   // Reload on clear or on reaching zero, so each tick period is exactly CLKS_PER_BIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (i_clr || (cnt_q == '0)) begin
         cnt_q <= CW'(CLKS_PER_BIT - 1);
      end else begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign o_tick = (cnt_q == '0);

endmodule

// File: rtl/ra_uart_tx.sv
// rtl/ra_uart_tx.sv - UART-style frame transmitter for rolling-average results with one-entry holding buffer
module ra_uart_tx
   import ra_pkg::*;
#(
   parameter int BITS_PER_ELEM = RA_BITS_PER_ELEM,
   parameter int CLKS_PER_BIT  = 4,
   parameter int PARITY_EN     = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BITS_PER_ELEM-1:0] i_value,
   input  logic                     i_valid,
   output logic                     o_tx,
   output logic                     o_busy,
   output logic                     o_overrun
);

   localparam int BCW = (BITS_PER_ELEM > 1) ? $clog2(BITS_PER_ELEM) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS_PER_ELEM - 1);

   tx_state_e                state_q;
   logic [BITS_PER_ELEM-1:0] shift_q;
   logic [BITS_PER_ELEM-1:0] hold_q;
   logic                     hold_full_q;
   logic [BCW-1:0]           bit_q;
   logic                     par_q;
   logic                     tx_q;
   logic                     busy_q;
   logic                     overrun_q;
   logic                     baud_clr;
   logic                     baud_tick;

   // Every other state entry happens on a tick, where the counter reloads by itself.
   assign baud_clr = (state_q == ST_IDLE) && i_valid;

   ra_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .i_clr (baud_clr),
      .o_tick(baud_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_q       <= '0;
         par_q       <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // Arrivals during a frame park in the holding buffer; newest value wins.
         if ((state_q != ST_IDLE) && i_valid) begin
            hold_q      <= i_value;
            hold_full_q <= 1'b1;
            if (hold_full_q) overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  shift_q <= i_value;
                  par_q   <= 1'b0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (baud_tick) begin
                  tx_q    <= shift_q[0];
                  par_q   <= par_q ^ shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_q   <= '0;
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  if (bit_q == LAST_BIT) begin
                     if (PARITY_EN != 0) begin
                        tx_q    <= par_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     bit_q   <= bit_q + BCW'(1);
                     tx_q    <= shift_q[0];
                     par_q   <= par_q ^ shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end
            end
            ST_PARITY: begin
               if (baud_tick) begin
                  tx_q    <= 1'b1;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (baud_tick) begin
                  // A same-cycle arrival bypasses the buffer and is the value sent next.
                  if (hold_full_q || i_valid) begin
                     shift_q     <= i_valid ? i_value : hold_q;
                     hold_full_q <= 1'b0;
                     par_q       <= 1'b0;
                     tx_q        <= 1'b0;
                     state_q     <= ST_START;
                  end else begin
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_tx      = tx_q;
   assign o_busy    = busy_q;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_ra_uart_tx.sv
// tb/tb_ra_uart_tx.sv - directed self-checking bench for ra_uart_tx
module tb_ra_uart_tx;
   import ra_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] in_value = '0;
   logic       in_valid = 1'b0;
   logic       tx, busy, overrun;
   logic [4:0] in_value_b = '0;
   logic       in_valid_b = 1'b0;
   logic       tx_b, busy_b, overrun_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ra_uart_tx #(.BITS_PER_ELEM(5), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
      .clk(clk), .rst(rst), .i_value(in_value), .i_valid(in_valid),
      .o_tx(tx), .o_busy(busy), .o_overrun(overrun)
   );

   ra_uart_tx #(.BITS_PER_ELEM(5), .CLKS_PER_BIT(2), .PARITY_EN(0)) dut_b (
      .clk(clk), .rst(rst), .i_value(in_value_b), .i_valid(in_valid_b),
      .o_tx(tx_b), .o_busy(busy_b), .o_overrun(overrun_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int sel, input logic [4:0] v);
      @(negedge clk);
      if (sel == 0) begin in_valid = 1'b1; in_value = v; end
      else          begin in_valid_b = 1'b1; in_value_b = v; end
   endtask

   // Checks one frame cycle by cycle; ia/ib are cycle indices at which a new value is driven.
   task automatic run_frame(input int sel, input int nb, input int cpb, input logic [15:0] exp_bits,
                            input int ov_from, input int ia, input logic [4:0] va,
                            input int ib, input logic [4:0] vb);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < cpb; c++) begin
            int  idx;
            logic drv;
            idx = b * cpb + c;
            @(negedge clk);
            chk($sformatf("tx[%0d]", idx),   sel ? tx_b : tx, exp_bits[b]);
            chk($sformatf("busy[%0d]", idx), sel ? busy_b : busy, 1'b1);
            chk($sformatf("ovr[%0d]", idx),  sel ? overrun_b : overrun, idx >= ov_from);
            drv = (idx == ia) || (idx == ib);
            if (sel == 0) begin in_valid = drv; in_value = (idx == ib) ? vb : va; end
            else          begin in_valid_b = drv; in_value_b = (idx == ib) ? vb : va; end
         end
      end
   endtask

   task automatic idle_chk(input int sel, input string tag);
      @(negedge clk);
      chk({tag, "_tx"},   sel ? tx_b : tx, 1'b1);
      chk({tag, "_busy"}, sel ? busy_b : busy, 1'b0);
   endtask

   initial begin
      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", tx, 1'b1);
         chk("rst_busy", busy, 1'b0);
         chk("rst_ovr", overrun, 1'b0);
         chk("rst_tx_b", tx_b, 1'b1);
      end
      rst = 1'b0;
      idle_chk(0, "post_rst");
      chk("frame_len", frame_bits(5, 1), 8);

      // Single frame: 22 -> 0,0,1,1,0,1,(par)1,1.
      send(0, 5'd22);
      run_frame(0, 8, 4, 16'b1110_1100, 1000, -1, 5'd0, -1, 5'd0);
      idle_chk(0, "single_end");

      // Back-to-back: 31 then 0 queued mid-frame.
      send(0, 5'd31);
      run_frame(0, 8, 4, 16'b1111_1110, 1000, 10, 5'd0, -1, 5'd0);
      run_frame(0, 8, 4, 16'b1000_0000, 1000, -1, 5'd0, -1, 5'd0);
      idle_chk(0, "b2b_end");

      // Overrun: 1, then 2, then 3 overwriting 2.
      send(0, 5'd1);
      run_frame(0, 8, 4, 16'b1100_0010, 10, 5, 5'd2, 9, 5'd3);
      run_frame(0, 8, 4, 16'b1000_0110, 0, -1, 5'd0, -1, 5'd0);
      idle_chk(0, "ovr_end");
      chk("ovr_sticky", overrun, 1'b1);

      // Reset in the middle of a frame.
      send(0, 5'd22);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ovr", overrun, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) idle_chk(0, "midrst_quiet");
      send(0, 5'd22);
      run_frame(0, 8, 4, 16'b1110_1100, 1000, -1, 5'd0, -1, 5'd0);
      idle_chk(0, "midrst_new_end");

      // No parity, 2 clocks per bit: 5 then 26 arriving on the final stop cycle.
      send(1, 5'd5);
      run_frame(1, 7, 2, 16'b100_1010, 1000, 13, 5'd26, -1, 5'd0);
      run_frame(1, 7, 2, 16'b111_0100, 1000, -1, 5'd0, -1, 5'd0);
      idle_chk(1, "last_cycle_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ra_uart_tx.md
# ra_uart_tx

Serial output stage directly downstream of the rolling-average unit. It consumes each new 5-bit rolling-average result and its one-cycle update strobe, then transmits the value as a UART-style frame on a single spare output pin. Up to one result may wait in a one-entry holding buffer while a frame is in flight. Sits beside the parallel output bits in the top-level pin map and drives one of the unused `io_out` bits.

## Interface
- `BITS_PER_ELEM`, 5: data bits per frame, equal to the rolling-average output width.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; legal range 2..255.
- `PARITY_EN`, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
- `clk  input  1`: sole clock, shared with the shift register line and the rolling average.
- `rst  input  1`: synchronous, active-high reset.
- `i_value  input  BITS_PER_ELEM`: rolling-average result to transmit.
- `i_valid  input  1`: one-cycle strobe marking `i_value` as new; sampled every clock.
- `o_tx  output  1`: serial line; idles at 1.
- `o_busy  output  1`: high while a frame is in flight or the holding buffer is full.
- `o_overrun  output  1`: sticky flag; set when a held value is overwritten.

## Operation
- **Frame format, LSB first:** start bit 0, then `BITS_PER_ELEM` data bits, then parity if `PARITY_EN`, then stop bit 1. Frame length F = (2 + BITS_PER_ELEM + PARITY_EN) bits.
- **Parity:** even. The parity bit is the XOR of the data bits.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on accept.
  - START→DATA after one bit time.
  - DATA→PARITY (or STOP if `PARITY_EN`=0) after the last data bit.
  - PARITY→STOP after one bit time.
  - STOP→START if the holding buffer is full; otherwise STOP→IDLE.
- **Bit counter:** 0..BITS_PER_ELEM-1 within DATA.
- **Baud counter:** 0..CLKS_PER_BIT-1. It resets on every state entry and on every data-bit advance.
- **Accept rules:**
  - IDLE with `i_valid`: the value goes straight into the shift register and the FSM enters START.
  - Non-IDLE with `i_valid` and the holding buffer empty: the value goes into the holding buffer.
  - Non-IDLE with `i_valid` and the holding buffer full: the holding buffer is overwritten (newest value wins) and `o_overrun` is set.
- **Last stop cycle with `i_valid`:** a value arriving on the final cycle of STOP is held, or overwrites the held value, and is the one sent back-to-back.
- **Loading a held value:** when the FSM leaves STOP with the holding buffer full, the held value loads into the shift register and the holding buffer is marked empty in the same cycle.
- **Reset values:** `o_tx`=1, `o_busy`=0, `o_overrun`=0, FSM=IDLE, holding buffer empty, all counters 0. Reset asserted mid-frame aborts the frame; `o_tx` returns to 1 on the next clock edge.
- **`o_overrun`** clears only on `rst`.

## Timing
- `o_tx` is registered.
- **Start latency:** `i_valid` in IDLE sampled at edge N puts `o_tx`=0 from edge N+1.
- **Bit length:** each bit holds exactly `CLKS_PER_BIT` cycles. A frame occupies F×`CLKS_PER_BIT` cycles.
- **Back-to-back frames:** no idle gap. The next start bit begins on the cycle after the last stop cycle.
- **`o_busy`:**
  - Rises on the edge following an accept in IDLE.
  - Falls on the edge where STOP→IDLE, i.e. the first IDLE cycle.
  - Stays high continuously across back-to-back frames.
- **Accept latency:** none. `i_valid` is never ignored in any state outside reset.

## Structure
- **Shared package `ra_pkg`:**
  - `BITS_PER_ELEM` default.
  - FSM state enum (3-bit).
  - Frame-length helper function `frame_bits(bits, parity_en)`.
- **Sub-module `ra_baud_tick`:** parameterized down-counter with clear input, emitting a one-cycle `o_tick` every `CLKS_PER_BIT` cycles.
- **Main module contents:** FSM, shift register, holding buffer, parity accumulator.
- **Top-level hookup:** `i_value` to `ra_out`; `i_valid` to a registered copy of the rolling average's `start_calc`, delayed to match the rolling-average output latency; `o_tx` to `io_out[5]`.

## Test plan
All scenarios use defaults: `BITS_PER_ELEM`=5, `CLKS_PER_BIT`=4, `PARITY_EN`=1, so F=8 bits = 32 cycles.

- **Reset values:** hold `rst` for 3 cycles → `o_tx`=1, `o_busy`=0, `o_overrun`=0 throughout and after.
- **Single frame:** `i_value`=22 (10110b), `i_valid` one cycle in IDLE → `o_tx` per 4-cycle bit is 0, 0, 1, 1, 0, 1, 1 (parity), 1. `o_busy` is high for exactly 32 cycles.
- **Back-to-back via holding buffer:** send 31 in IDLE, then 0 at cycle 10 → frame 31 (0,1,1,1,1,1,1,1) is immediately followed by frame 0 (0,0,0,0,0,0,0,1). 64 contiguous busy cycles, `o_overrun`=0.
- **Overrun:** send 1, then 2 at cycle 5, then 3 at cycle 9 → the second frame carries 3 and `o_overrun`=1 from cycle 10 until reset.
- **Reset mid-frame:** start 22, assert `rst` at cycle 12 → `o_tx`=1 next cycle, `o_busy`=0, no further frame. A new `i_valid` after reset starts a clean frame with 1-cycle latency.
- **Last-cycle arrival:** `PARITY_EN`=0, `CLKS_PER_BIT`=2; `i_valid` on the final stop cycle of frame A → frame B's start bit follows with zero idle cycles.
